// File: rtl/rv32_dmem_pkg.sv
// rv32_dmem_pkg: size encodings, FSM states, latched request and byte-enable helper for the data-memory responder
package rv32_dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef struct packed {
    logic        we;
    logic        uns;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    return size == SIZE_B ? 4'b0001 << a : size == SIZE_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/rv32_dmem_responder_if.sv
// rv32_dmem_responder_if: request/response handshake bundle between execute stage and data memory
interface rv32_dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/rv32_dmem_ram.sv
// rv32_dmem_ram: single-port DEPTH_WORDS x 32 RAM, byte write enables, synchronous read (read when no lane is written)
module rv32_dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          i_en,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk_i)
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      if (i_be == 4'b0000) o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: RV32 load/store responder with IDLE/WAIT/RESP FSM and WAIT_CYCLES wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module rv32_dmem_responder import rv32_dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic clk_i,
  input logic rst_n,
  rv32_dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t      r_state, w_next;
  req_t        r_req, w_live, w_cur;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic        w_hs, w_go, w_err, w_mis;
  logic [31:0] w_word, w_lane, w_load;
  always_comb begin
    w_live = {bus.req_we_i, bus.req_unsigned_i, bus.req_size_i, bus.req_addr_i, bus.req_wdata_i};
`ifdef DMEM_MISALIGN_TRAP_EN
    w_mis = 1'b0;
`else
    w_mis = 1'b0;
    w_live.addr[0] = w_live.addr[0] & (w_live.size == SIZE_B);
    w_live.addr[1] = w_live.addr[1] & (w_live.size != SIZE_W);
`endif
    // RESP can be entered on the handshake edge itself, so the live request drives the RAM from IDLE
    w_cur = r_state == ST_IDLE ? w_live : r_req;
`ifdef DMEM_MISALIGN_TRAP_EN
    w_mis = (w_cur.size == SIZE_H && w_cur.addr[0]) || (w_cur.size == SIZE_W && w_cur.addr[1:0] != 2'b00);
`endif
    w_err = w_cur.size == 2'b11 || {2'b00, w_cur.addr[31:2]} >= 32'(DEPTH_WORDS) || w_mis;
  end
  always_comb begin
    w_hs = r_state == ST_IDLE && bus.req_valid_i;
    w_go = (w_hs && WAIT_CYCLES == 0) || (r_state == ST_WAIT && r_cnt == 4'd0);
    w_next = w_go ? ST_RESP : w_hs ? ST_WAIT : (r_state == ST_RESP && bus.rsp_ready_i) ? ST_IDLE : r_state;
    bus.req_ready_o = r_state == ST_IDLE;
    bus.rsp_valid_o = r_state == ST_RESP;
    bus.rsp_err_o = r_state == ST_RESP && r_err;
    bus.rsp_rdata_o = (r_state == ST_RESP && !r_err && !r_req.we) ? w_load : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      r_req <= '0;
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_req <= w_live;
        r_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_go) r_err <= w_err;
    end
  rv32_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i  (clk_i),
    .i_en   (w_go && !w_err),
    .i_be   (w_cur.we ? byte_en(w_cur.size, w_cur.addr[1:0]) : 4'b0000),
    .i_addr (w_cur.addr[AW+1:2]),
    .i_wdata(w_cur.size == SIZE_B ? {4{w_cur.wdata[7:0]}} : w_cur.size == SIZE_H ? {2{w_cur.wdata[15:0]}} : w_cur.wdata),
    .o_rdata(w_word)
  );
  // the RAM output register holds the loaded word through RESP; lane select and extension follow it
  always_comb begin
    w_lane = w_word >> {r_req.addr[1:0], 3'b000};
    w_load = r_req.size == SIZE_B ? {{24{!r_req.uns & w_lane[7]}}, w_lane[7:0]} :
             r_req.size == SIZE_H ? {{16{!r_req.uns & w_lane[15]}}, w_lane[15:0]} : w_lane;
  end
endmodule

// File: doc/rv32_dmem_responder.md
RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS SHALL default to 1024; it is the number of 32-bit words in the internal data memory.
REQ-002 Parameter WAIT_CYCLES SHALL default to 0; it is the number of extra wait states inserted per access, legal range 0..15.
REQ-003 clk_i  in  1  sole clock; every state element updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i  in  1  the requester (execute stage) presents an access.
REQ-006 req_ready_o  out  1  the responder accepts the access this cycle.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 req_unsigned_i  in  1  zero-extend the load result (lbu/lhu); 0 = sign-extend.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid_o  out  1  a response is available.
REQ-013 rsp_ready_i  in  1  the requester consumes the response.
REQ-014 rsp_rdata_o  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err_o  out  1  the access was rejected; qualified by rsp_valid_o.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE; a handshake occurs when req_valid_i & req_ready_o at a rising edge.
REQ-018 On handshake, addr, size, we, unsigned and wdata SHALL be latched; the next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-019 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and move to RESP after the cycle in which the counter equals 0.
REQ-020 rsp_valid_o SHALL rise exactly 1+WAIT_CYCLES cycles after the handshake edge and SHALL hold, with stable data, until rsp_ready_i is sampled at 1; the FSM then returns to IDLE.
REQ-021 There SHALL be no back-to-back accept: at most one access is outstanding, and the minimum spacing between handshakes is 2+WAIT_CYCLES cycles.
REQ-022 A store SHALL write the memory once, on the edge that enters RESP; byte enables are derived from size and addr[1:0], and the data is shifted into the addressed lane(s).
REQ-023 A load SHALL read the addressed word, select the lane by addr[1:0], extend it per req_unsigned_i, and register the result into rsp_rdata_o on the edge that enters RESP.
REQ-024 size=11, or word index addr[31:2] >= DEPTH_WORDS, SHALL give rsp_err_o=1 and rsp_rdata_o=0, with no memory write.
REQ-025 rsp_err_o and rsp_rdata_o SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-026 Asserting rst_n low at any time, including mid-access, SHALL immediately force the state to IDLE and set rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, the counter to 0 and the latched request to 0; req_ready_o=1 while in reset.
REQ-027 Memory contents SHALL NOT be reset; a store whose RESP-entry edge has not occurred before reset SHALL NOT be written.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN, when defined, SHALL flag a half access with addr[0]=1, or a word access with addr[1:0]!=0, as an error per REQ-024.
REQ-029 When DMEM_MISALIGN_TRAP_EN is undefined, the low address bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=0), and the access SHALL proceed without error.

Structure
REQ-030 Package rv32_dmem_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state encoding, and the function that computes byte enables from size and address.
REQ-031 Sub-module rv32_dmem_ram SHALL implement a single-port DEPTH_WORDS x 32 RAM with 4 byte-write enables and a synchronous read.

Verification
REQ-032 WAIT_CYCLES=0: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rsp_rdata_o=0xDEADBEEF, rsp_valid_o rises 1 cycle after each handshake.
REQ-033 Store byte 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80 and lbu 0x13 -> 0x00000080; the word at 0x10 reads 0x80ADBEEF.
REQ-034 WAIT_CYCLES=3: load with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o rises 4 cycles after the handshake, the data stays stable, req_ready_o stays 0, and IDLE is re-entered after rsp_ready_i=1.
REQ-035 Load word from 0x12: with DMEM_MISALIGN_TRAP_EN -> rsp_err_o=1, rsp_rdata_o=0; without it -> the data at 0x10 is returned with rsp_err_o=0; an address of DEPTH_WORDS*4 -> rsp_err_o=1 in both builds.
REQ-036 Store 0x12345678 to 0x20 with rst_n pulsed low after the handshake but before RESP -> rsp_valid_o=0 immediately, and a later load of 0x20 returns the prior contents unchanged.
